// File: rtl/in_trans_pkg.sv
// Shared USB transaction package: IN/OUT FSM states, retry and timeout limits.
// Imported by the IN/OUT transaction FSMs and their counters.
package in_trans_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SEND_IN,
        WAIT_RESPONSE,
        WAIT_SEND_NAK,
        WAIT_SEND_ACK
    } in_state_e;

    localparam int CLK_CNT_W   = 8;
    localparam int RETRY_CNT_W = 4;

    localparam int IN_TIMEOUT_CYCLES = 255;
    localparam int IN_MAX_RETRIES    = 8;

    localparam int OUT_TIMEOUT_CYCLES = 255;
    localparam int OUT_MAX_RETRIES    = 8;

endpackage

// File: rtl/in_trans_trans_counter.sv
// Generic clear/increment counter used for the clock, timeout and corrupt counts.
// Clear wins over increment; optional saturation at all-ones.
module trans_counter
    import in_trans_pkg::*;
#(
    parameter int WIDTH    = CLK_CNT_W,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_max;

    always_comb begin
        at_max = &cnt_q;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(SATURATE && at_max)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/in_trans.sv
// USB IN transaction FSM: sends IN, waits for DATA0, ACKs or NAKs with retries.
// Mealy outputs are forced low while reset_n is asserted.
module in_trans
    import in_trans_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = IN_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = IN_MAX_RETRIES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    output logic sending,
    output logic done,
    output logic success,
    output logic failure,
    input  logic sent,
    output logic send_IN,
    output logic send_ACK,
    output logic send_NAK,
    input  logic rec_start,
    input  logic rec_DATA0,
    input  logic rec_corrupt
);

    localparam logic [CLK_CNT_W-1:0]   TO_LIMIT    = CLK_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [RETRY_CNT_W-1:0] RETRY_LIMIT = RETRY_CNT_W'(MAX_RETRIES);

    in_state_e state_q;
    in_state_e state_d;

    logic [CLK_CNT_W-1:0]   clk_cnt;
    logic [RETRY_CNT_W-1:0] to_cnt;
    logic [RETRY_CNT_W-1:0] corrupt_cnt;

    logic clk_clr;
    logic retry_clr;
    logic to_inc;
    logic cor_inc;
    logic retry_hit;
    logic timeout_hit;

    assign retry_hit   = (to_cnt == RETRY_LIMIT) || (corrupt_cnt == RETRY_LIMIT);
    assign timeout_hit = (clk_cnt == TO_LIMIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = WAIT_SEND_IN;
            end
            WAIT_SEND_IN: begin
                if (sent) state_d = WAIT_RESPONSE;
            end
            WAIT_RESPONSE: begin
                if (rec_start)        state_d = WAIT_RESPONSE;
                else if (retry_hit)   state_d = IDLE;
                else if (rec_DATA0)   state_d = WAIT_SEND_ACK;
                else if (rec_corrupt) state_d = WAIT_SEND_NAK;
                else if (timeout_hit) state_d = WAIT_SEND_NAK;
            end
            WAIT_SEND_NAK: begin
                if (sent) state_d = WAIT_RESPONSE;
            end
            WAIT_SEND_ACK: begin
                if (sent) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter controls follow the same priority as the WAIT_RESPONSE transitions.
    always_comb begin
        clk_clr   = 1'b0;
        retry_clr = 1'b0;
        to_inc    = 1'b0;
        cor_inc   = 1'b0;
        unique case (state_q)
            WAIT_SEND_IN: begin
                clk_clr   = sent;
                retry_clr = sent;
            end
            WAIT_RESPONSE: begin
                if (rec_start) begin
                    clk_clr = 1'b1;
                end else if (!retry_hit && !rec_DATA0) begin
                    cor_inc = rec_corrupt;
                    to_inc  = !rec_corrupt && timeout_hit;
                end
            end
            WAIT_SEND_NAK: begin
                clk_clr = sent;
            end
            default: ;
        endcase
    end

    always_comb begin
        sending  = 1'b0;
        done     = 1'b0;
        success  = 1'b0;
        failure  = 1'b0;
        send_IN  = 1'b0;
        send_ACK = 1'b0;
        send_NAK = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                IDLE: begin
                    send_IN = start;
                end
                WAIT_SEND_IN: begin
                    sending = !sent;
                end
                WAIT_RESPONSE: begin
                    if (!rec_start) begin
                        if (retry_hit) begin
                            done    = 1'b1;
                            failure = 1'b1;
                        end else if (rec_DATA0) begin
                            send_ACK = 1'b1;
                        end else if (rec_corrupt || timeout_hit) begin
                            send_NAK = 1'b1;
                        end
                    end
                end
                WAIT_SEND_NAK: begin
                    sending = !sent;
                end
                WAIT_SEND_ACK: begin
                    sending = !sent;
                    done    = sent;
                    success = sent;
                end
                default: ;
            endcase
        end
    end

    trans_counter #(
        .WIDTH    (CLK_CNT_W),
        .SATURATE (1'b0)
    ) u_clk_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clk_clr),
        .inc     (1'b1),
        .count   (clk_cnt)
    );

    trans_counter #(
        .WIDTH    (RETRY_CNT_W),
        .SATURATE (1'b1)
    ) u_to_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (retry_clr),
        .inc     (to_inc),
        .count   (to_cnt)
    );

    trans_counter #(
        .WIDTH    (RETRY_CNT_W),
        .SATURATE (1'b1)
    ) u_corrupt_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (retry_clr),
        .inc     (cor_inc),
        .count   (corrupt_cnt)
    );

endmodule

// File: doc/in_trans.md
IN_TRANS -- requirements
Module: in_trans

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, idle cycles in WAIT_RESPONSE before a timeout.
REQ-002 Parameter MAX_RETRIES, default 8, timeout or corrupt-packet limit before failure.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request from the read/write FSM to run one IN transaction.
REQ-006 sending  output  1  high while waiting on the packet sender.
REQ-007 done  output  1  one-cycle pulse at transaction end.
REQ-008 success  output  1  one-cycle pulse with done when DATA0 was accepted and ACKed.
REQ-009 failure  output  1  one-cycle pulse with done when the retry limit was reached.
REQ-010 sent  input  1  one-cycle pulse from the packet sender: packet fully transmitted.
REQ-011 send_IN, send_ACK, send_NAK  output  1 each  one-cycle packet requests to the packet sender.
REQ-012 rec_start  input  1  packet receiver has detected an incoming packet in progress.
REQ-013 rec_DATA0  input  1  one-cycle pulse: DATA0 received with good PID and CRC.
REQ-014 rec_corrupt  input  1  one-cycle pulse: packet received with bad PID, bad CRC or an unexpected PID.

Function
REQ-015 States: IDLE, WAIT_SEND_IN, WAIT_RESPONSE, WAIT_SEND_NAK, WAIT_SEND_ACK.
REQ-016 All outputs are Mealy and combinational from the state and inputs, and are 0 unless stated.
REQ-017 IDLE, start=1: send_IN=1 in the same cycle, then go to WAIT_SEND_IN; start=0 holds IDLE.
REQ-018 start is ignored in any state other than IDLE.
REQ-019 WAIT_SEND_IN, sent=0: sending=1, hold the state.
REQ-020 WAIT_SEND_IN, sent=1: clear the clock counter, timeout counter and corrupt counter, then go to WAIT_RESPONSE.
REQ-021 Clock counter: 8-bit wide, increments every cycle unless cleared, wraps 255->0.
REQ-022 WAIT_RESPONSE priority, highest first, as follows:
  (a) rec_start: clear the clock counter (freezes the timeout) and hold the state.
  (b) to_cnt==MAX_RETRIES or corrupt_cnt==MAX_RETRIES: done=1, failure=1, go to IDLE.
  (c) rec_DATA0: send_ACK=1, go to WAIT_SEND_ACK.
  (d) rec_corrupt: send_NAK=1, increment corrupt_cnt, go to WAIT_SEND_NAK.
  (e) clock counter == TIMEOUT_CYCLES: send_NAK=1, increment to_cnt, go to WAIT_SEND_NAK.
  (f) otherwise hold the state.
REQ-023 When rec_DATA0 and a timeout occur in the same cycle, rec_DATA0 wins; the counters do not change.
REQ-024 WAIT_SEND_NAK, sent=0: sending=1, hold the state.
REQ-025 WAIT_SEND_NAK, sent=1: clear the clock counter, go to WAIT_RESPONSE; the retry counters are kept.
REQ-026 WAIT_SEND_ACK, sent=0: sending=1, hold the state.
REQ-027 WAIT_SEND_ACK, sent=1: done=1, success=1, go to IDLE.
REQ-028 to_cnt and corrupt_cnt are 4-bit and saturate; they are checked before incrementing, so at most MAX_RETRIES NAKs are sent per cause.
REQ-029 done coincides with exactly one of success or failure, never both.

Reset
REQ-030 reset_n low forces IDLE and all counters to 0 asynchronously, at any time including mid-transaction.
REQ-031 Outputs during and immediately after reset: all 0.
REQ-032 A packet request that was in flight when reset occurred is abandoned; no done is produced for it.

Structure
REQ-033 The state enum, TIMEOUT_CYCLES and MAX_RETRIES defaults live in the shared USB package, alongside the OUT-transaction constants.
REQ-034 One sub-module, trans_counter (clear/increment/width parameter), is instantiated three times: clock, timeout and corrupt counters.
REQ-035 in_trans is flat otherwise and lives next to the OUT transaction FSM under the read/write FSM.

Verification
REQ-036 Happy path: start; sent after 10 cycles; rec_DATA0 after 20 cycles -> send_ACK pulses that cycle; sent -> done=success=1 one cycle, back in IDLE.
REQ-037 Timeout: no response for 255 cycles after the IN is sent -> send_NAK; after 8 timeouts with no response -> done=failure=1; exactly 8 send_NAK pulses seen.
REQ-038 Corruption: 3 rec_corrupt (each followed by send_NAK and sent), then rec_DATA0 -> send_ACK, success; corrupt_cnt reached 3 only.
REQ-039 Freeze: rec_start asserted from cycle 250 to cycle 300 of a wait, then rec_DATA0 -> no timeout NAK; send_ACK issued.
REQ-040 Simultaneous: rec_DATA0 in the same cycle the counter reaches 255 -> send_ACK=1 and send_NAK=0.
REQ-041 Reset mid-WAIT_SEND_NAK -> IDLE, all outputs 0, no done; a following start runs a clean transaction.
